uart_echo_buffer: RTL

Parametrised byte-stream buffer that sits between the UART receiver and the UART transmitter in the loopback path. It replaces the direct receiver-to-transmitter wire, so back-to-back received bytes are queued instead of lost while the transmitter is busy. It adds an optional case-conversion mode, a fill-level readout, a sticky overflow flag, and a last-byte register that drives the 7-segment decoder.

---
 rtl/uart_echo_buffer_pkg.sv | 32 +++
 rtl/uart_echo_buffer_sync_fifo.sv | 67 ++++++
 rtl/uart_echo_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_echo_buffer_pkg.sv
// Shared constants, TX handshake states and the ASCII case transform for the
// UART loopback echo buffer.
package uart_echo_buffer_pkg;

  localparam int CASE_PASS  = 0;
  localparam int CASE_UPPER = 1;
  localparam int CASE_LOWER = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } txState_e;

  localparam logic [7:0] ASCII_UPPER_A    = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z    = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

  // Letters outside the selected range, and every byte in pass mode, are untouched.
  function automatic logic [7:0] caseXform(input logic [7:0] b, input int mode);
    logic [7:0] r;
    r = b;
    if (mode == CASE_UPPER && b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z)
      r = b - ASCII_CASE_DELTA;
    else if (mode == CASE_LOWER && b >= ASCII_UPPER_A && b <= ASCII_UPPER_Z)
      r = b + ASCII_CASE_DELTA;
    return r;
  endfunction

endpackage

// File: rtl/uart_echo_buffer_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; a push while full is
// accepted only when a pop happens in the same cycle, and clear wins over both.
module sync_fifo
  import uart_echo_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [LW-1:0]    o_level,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             doPush, doPop;

  assign o_empty = (level_q == '0);
  assign o_full  = (level_q == LW'(DEPTH));
  assign o_level = level_q;
  assign o_data  = mem_q[rdPtr_q];

  assign doPop  = i_pop && !o_empty && !i_clear;
  assign doPush = i_push && (!o_full || doPop) && !i_clear;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (i_clear) begin
      rdPtr_d = wrPtr_q;
      level_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
      level_d = level_q + LW'(doPush) - LW'(doPop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (doPush) mem_q[wrPtr_q] <= i_data;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Queues received bytes between the UART receiver and transmitter, optionally
// case-converting them, and launches one byte per transmitter busy cycle.
module uart_echo_buffer
  import uart_echo_buffer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int CASE_MODE = CASE_PASS,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_valid,
  input  logic [WIDTH-1:0] i_rx_byte,
  input  logic             i_tx_busy,
  input  logic             i_clear,
  output logic             o_tx_start,
  output logic [WIDTH-1:0] o_tx_byte,
  output logic [WIDTH-1:0] o_last_byte,
  output logic [LW-1:0]    o_level,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);

  logic [WIDTH-1:0] pushData, fifoData;
  logic             fifoEmpty, fifoFull;
  txState_e         state_q, state_d;
  logic             txStart_q, txStart_d;
  logic [WIDTH-1:0] txByte_q, txByte_d;
  logic [WIDTH-1:0] lastByte_q, lastByte_d;
  logic             overflow_q, overflow_d;
  logic             launch;

  if (WIDTH == 8 && CASE_MODE != CASE_PASS) begin : gXform
    assign pushData = caseXform(i_rx_byte, CASE_MODE);
  end else begin : gPass
    assign pushData = i_rx_byte;
  end

  // A flush must not launch a byte it is about to discard.
  assign launch = (state_q == IDLE) && !fifoEmpty && !i_tx_busy && !i_clear;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uFifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_rx_valid),
    .i_pop   (launch),
    .i_clear (i_clear),
    .i_data  (pushData),
    .o_data  (fifoData),
    .o_level (o_level),
    .o_empty (fifoEmpty),
    .o_full  (fifoFull)
  );

  always_comb begin
    state_d    = state_q;
    txStart_d  = 1'b0;
    txByte_d   = txByte_q;
    lastByte_d = i_rx_valid ? i_rx_byte : lastByte_q;
    overflow_d = overflow_q;
    if (i_clear)
      overflow_d = 1'b0;
    else if (i_rx_valid && fifoFull && !launch)
      overflow_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          txStart_d = 1'b1;
          txByte_d  = fifoData;
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (i_tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!i_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      txStart_q  <= 1'b0;
      txByte_q   <= '0;
      lastByte_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txStart_q  <= txStart_d;
      txByte_q   <= txByte_d;
      lastByte_q <= lastByte_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_tx_start  = txStart_q;
  assign o_tx_byte   = txByte_q;
  assign o_last_byte = lastByte_q;
  assign o_empty     = fifoEmpty;
  assign o_full      = fifoFull;
  assign o_overflow  = overflow_q;

endmodule
